fetch_queue: RTL and testbench

- Instruction buffer between the fetch stage (select logic, BTB, gshare) and the decode stage.
- Each cycle it accepts the fetched instruction pair with its PC and prediction metadata, and presents up to two oldest instructions to decode.
- It decouples fetch from decode stalls and discards everything on a branch mispredict (flush).

---
 rtl/fetch_queue_pkg.sv | 19 +
 rtl/fetch_queue_storage.sv | 36 +++
 rtl/fetch_queue.sv | 121 ++++++++++++
 tb/tb_fetch_queue.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared widths and the packed entry layout for the fetch queue.
package fetch_queue_pkg;

    localparam int unsigned ADDR_LEN    = 32;
    localparam int unsigned INSN_LEN    = 32;
    localparam int unsigned GSH_BHR_LEN = 10;
    localparam int unsigned FQ_DEPTH    = 8;
    localparam int unsigned FQ_PTR_LEN  = 3;
    localparam int unsigned FQ_ENT_LEN  = INSN_LEN + ADDR_LEN * 2 + 1 + GSH_BHR_LEN;

    typedef struct packed {
        logic [INSN_LEN-1:0]    inst;
        logic [ADDR_LEN-1:0]    pc;
        logic [ADDR_LEN-1:0]    npc;
        logic                   pred;
        logic [GSH_BHR_LEN-1:0] bhr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// Entry array for the fetch queue: two write ports, two asynchronous read ports.
module fq_storage #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             we1,
    input  logic             we2,
    input  logic [PTR_W-1:0] waddr1,
    input  logic [PTR_W-1:0] waddr2,
    input  logic [WIDTH-1:0] wdata1,
    input  logic [WIDTH-1:0] wdata2,
    input  logic [PTR_W-1:0] raddr1,
    input  logic [PTR_W-1:0] raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write addresses are always wptr and wptr+1, so the ports never collide.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (we1 && waddr1 == PTR_W'(i)) begin
                mem_q[i] <= wdata1;
            end else if (we2 && waddr2 == PTR_W'(i)) begin
                mem_q[i] <= wdata2;
            end
        end
    end

    assign rdata1 = mem_q[raddr1];
    assign rdata2 = mem_q[raddr2];

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: pair enqueue, up-to-two dequeue, flush.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH,
    parameter int unsigned PTR_W = FQ_PTR_LEN
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   enq_valid,
    input  logic [ADDR_LEN-1:0]    enq_pc,
    input  logic [INSN_LEN-1:0]    enq_inst1,
    input  logic [INSN_LEN-1:0]    enq_inst2,
    input  logic                   enq_invalid2,
    input  logic                   enq_pred,
    input  logic [ADDR_LEN-1:0]    enq_npc,
    input  logic [GSH_BHR_LEN-1:0] enq_bhr,
    output logic                   enq_ready,
    output logic                   deq_valid1,
    output logic                   deq_valid2,
    output logic [INSN_LEN-1:0]    deq_inst1,
    output logic [INSN_LEN-1:0]    deq_inst2,
    output logic [ADDR_LEN-1:0]    deq_pc1,
    output logic [ADDR_LEN-1:0]    deq_pc2,
    output logic                   deq_pred1,
    output logic                   deq_pred2,
    output logic [ADDR_LEN-1:0]    deq_npc1,
    output logic [ADDR_LEN-1:0]    deq_npc2,
    output logic [GSH_BHR_LEN-1:0] deq_bhr1,
    output logic [GSH_BHR_LEN-1:0] deq_bhr2,
    input  logic                   deq_ready,
    output logic [PTR_W:0]         count
);

    localparam logic [PTR_W:0] ReadyMax = (PTR_W + 1)'(DEPTH - 2);

    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_enq;
    logic [1:0]       nenq, ndeq;
    fq_entry_t        wr1, wr2, rd1, rd2;

    assign enq_ready  = count_q <= ReadyMax;
    assign do_enq     = enq_valid && enq_ready && !flush;
    assign deq_valid1 = (count_q != '0) && !flush;
    assign deq_valid2 = (count_q >= (PTR_W + 1)'(2)) && !flush;
    assign count      = count_q;

    always_comb begin
        nenq = 2'd0;
        ndeq = 2'd0;
        if (do_enq) begin
            nenq = enq_invalid2 ? 2'd1 : 2'd2;
        end
        if (deq_ready) begin
            ndeq = {1'b0, deq_valid1} + {1'b0, deq_valid2};
        end
        wptr_d  = wptr_q + PTR_W'(nenq);
        rptr_d  = rptr_q + PTR_W'(ndeq);
        count_d = count_q + (PTR_W + 1)'(nenq) - (PTR_W + 1)'(ndeq);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Only the last enqueued entry carries fetch's prediction; an earlier one falls through.
    always_comb begin
        wr1.inst = enq_inst1;
        wr1.pc   = enq_pc;
        wr1.pred = enq_invalid2 ? enq_pred : 1'b0;
        wr1.npc  = enq_invalid2 ? enq_npc : enq_pc + ADDR_LEN'(4);
        wr1.bhr  = enq_bhr;
        wr2.inst = enq_inst2;
        wr2.pc   = enq_pc + ADDR_LEN'(4);
        wr2.pred = enq_pred;
        wr2.npc  = enq_npc;
        wr2.bhr  = enq_bhr;
    end

    fq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .WIDTH (FQ_ENT_LEN)
    ) u_storage (
        .clk    (clk),
        .we1    (do_enq),
        .we2    (do_enq && !enq_invalid2),
        .waddr1 (wptr_q),
        .waddr2 (wptr_q + PTR_W'(1)),
        .wdata1 (wr1),
        .wdata2 (wr2),
        .raddr1 (rptr_q),
        .raddr2 (rptr_q + PTR_W'(1)),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );

    always_comb begin
        deq_inst1 = deq_valid1 ? rd1.inst : '0;
        deq_pc1   = deq_valid1 ? rd1.pc   : '0;
        deq_pred1 = deq_valid1 ? rd1.pred : 1'b0;
        deq_npc1  = deq_valid1 ? rd1.npc  : '0;
        deq_bhr1  = deq_valid1 ? rd1.bhr  : '0;
        deq_inst2 = deq_valid2 ? rd2.inst : '0;
        deq_pc2   = deq_valid2 ? rd2.pc   : '0;
        deq_pred2 = deq_valid2 ? rd2.pred : 1'b0;
        deq_npc2  = deq_valid2 ? rd2.npc  : '0;
        deq_bhr2  = deq_valid2 ? rd2.bhr  : '0;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue plus hand sequences for reset and full.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset, flush, enq_valid, enq_invalid2, enq_pred, deq_ready;
    logic [ADDR_LEN-1:0]    enq_pc, enq_npc;
    logic [INSN_LEN-1:0]    enq_inst1, enq_inst2;
    logic [GSH_BHR_LEN-1:0] enq_bhr;
    logic                   enq_ready, deq_valid1, deq_valid2, deq_pred1, deq_pred2;
    logic [INSN_LEN-1:0]    deq_inst1, deq_inst2;
    logic [ADDR_LEN-1:0]    deq_pc1, deq_pc2, deq_npc1, deq_npc2;
    logic [GSH_BHR_LEN-1:0] deq_bhr1, deq_bhr2;
    logic [3:0]             count;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .enq_valid    (enq_valid),
        .enq_pc       (enq_pc),
        .enq_inst1    (enq_inst1),
        .enq_inst2    (enq_inst2),
        .enq_invalid2 (enq_invalid2),
        .enq_pred     (enq_pred),
        .enq_npc      (enq_npc),
        .enq_bhr      (enq_bhr),
        .enq_ready    (enq_ready),
        .deq_valid1   (deq_valid1),
        .deq_valid2   (deq_valid2),
        .deq_inst1    (deq_inst1),
        .deq_inst2    (deq_inst2),
        .deq_pc1      (deq_pc1),
        .deq_pc2      (deq_pc2),
        .deq_pred1    (deq_pred1),
        .deq_pred2    (deq_pred2),
        .deq_npc1     (deq_npc1),
        .deq_npc2     (deq_npc2),
        .deq_bhr1     (deq_bhr1),
        .deq_bhr2     (deq_bhr2),
        .deq_ready    (deq_ready),
        .count        (count)
    );

    typedef struct {
        logic        flush, ev, inv2, pred, dr;
        logic [31:0] pc, npc;
        int          cnt;
        logic        rdy, v1, v2, pred1, pred2;
        logic [31:0] pc1, pc2, npc1, npc2;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(logic fl, logic ev, logic [31:0] pc, logic inv2, logic pred,
                                logic [31:0] npc, logic dr, int cnt, logic rdy, logic v1,
                                logic v2, logic [31:0] pc1, logic [31:0] pc2, logic p1,
                                logic p2, logic [31:0] n1, logic [31:0] n2);
        vec_t v;
        v.flush = fl; v.ev = ev; v.pc = pc; v.inv2 = inv2; v.pred = pred; v.npc = npc;
        v.dr = dr; v.cnt = cnt; v.rdy = rdy; v.v1 = v1; v.v2 = v2; v.pc1 = pc1; v.pc2 = pc2;
        v.pred1 = p1; v.pred2 = p2; v.npc1 = n1; v.npc2 = n2;
        return v;
    endfunction

    function automatic logic [31:0] inst_of(logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(logic fl, logic ev, logic [31:0] pc, logic inv2, logic pred,
                         logic [31:0] npc, logic dr);
        flush = fl; enq_valid = ev; enq_pc = pc; enq_invalid2 = inv2; enq_pred = pred;
        enq_npc = npc; deq_ready = dr;
        enq_inst1 = inst_of(pc);
        enq_inst2 = inst_of(pc + 32'd4);
        enq_bhr = pc[11:2];
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset.count", 64'(count), 64'd0);
        chk("reset.enq_ready", 64'(enq_ready), 64'd1);
        chk("reset.valid1", 64'(deq_valid1), 64'd0);
        chk("reset.valid2", 64'(deq_valid2), 64'd0);

        //             fl ev pc      i2 pr npc      dr cnt rdy v1 v2 pc1     pc2     p1 p2 n1       n2
        vecs[0]  = mk(0, 1, 'h0,   0, 0, 'h8,   0, 0, 1, 0, 0, 'h0,  'h0,  0, 0, 'h0,  'h0);
        vecs[1]  = mk(0, 1, 'h8,   0, 0, 'h10,  0, 2, 1, 1, 1, 'h0,  'h4,  0, 0, 'h4,  'h8);
        vecs[2]  = mk(0, 1, 'h10,  0, 0, 'h18,  0, 4, 1, 1, 1, 'h0,  'h4,  0, 0, 'h4,  'h8);
        vecs[3]  = mk(0, 1, 'h18,  0, 0, 'h20,  0, 6, 1, 1, 1, 'h0,  'h4,  0, 0, 'h4,  'h8);
        vecs[4]  = mk(0, 1, 'h99,  0, 0, 'h0,   1, 8, 0, 1, 1, 'h0,  'h4,  0, 0, 'h4,  'h8);
        vecs[5]  = mk(0, 0, 'h0,   0, 0, 'h0,   1, 6, 1, 1, 1, 'h8,  'hC,  0, 0, 'hC,  'h10);
        vecs[6]  = mk(0, 0, 'h0,   0, 0, 'h0,   1, 4, 1, 1, 1, 'h10, 'h14, 0, 0, 'h14, 'h18);
        vecs[7]  = mk(0, 0, 'h0,   0, 0, 'h0,   1, 2, 1, 1, 1, 'h18, 'h1C, 0, 0, 'h1C, 'h20);
        vecs[8]  = mk(0, 1, 'h4,   1, 1, 'h100, 0, 0, 1, 0, 0, 'h0,  'h0,  0, 0, 'h0,  'h0);
        vecs[9]  = mk(0, 1, 'h20,  0, 1, 'h80,  0, 1, 1, 1, 0, 'h4,  'h0,  1, 0, 'h100, 'h0);
        vecs[10] = mk(0, 0, 'h0,   0, 0, 'h0,   1, 3, 1, 1, 1, 'h4,  'h20, 1, 0, 'h100, 'h24);
        vecs[11] = mk(0, 0, 'h0,   0, 0, 'h0,   1, 1, 1, 1, 0, 'h24, 'h0,  1, 0, 'h80, 'h0);
        vecs[12] = mk(0, 1, 'h40,  1, 0, 'h44,  0, 0, 1, 0, 0, 'h0,  'h0,  0, 0, 'h0,  'h0);
        vecs[13] = mk(0, 1, 'h48,  0, 0, 'h50,  1, 1, 1, 1, 0, 'h40, 'h0,  0, 0, 'h44, 'h0);
        vecs[14] = mk(0, 1, 'h50,  0, 0, 'h58,  1, 2, 1, 1, 1, 'h48, 'h4C, 0, 0, 'h4C, 'h50);
        vecs[15] = mk(0, 1, 'h58,  0, 0, 'h60,  0, 2, 1, 1, 1, 'h50, 'h54, 0, 0, 'h54, 'h58);
        vecs[16] = mk(0, 1, 'h60,  0, 0, 'h68,  0, 4, 1, 1, 1, 'h50, 'h54, 0, 0, 'h54, 'h58);
        vecs[17] = mk(0, 1, 'h68,  0, 0, 'h70,  1, 6, 1, 1, 1, 'h50, 'h54, 0, 0, 'h54, 'h58);
        vecs[18] = mk(0, 1, 'h70,  1, 0, 'h74,  1, 6, 1, 1, 1, 'h58, 'h5C, 0, 0, 'h5C, 'h60);
        vecs[19] = mk(1, 1, 'h78,  0, 0, 'h80,  1, 5, 1, 0, 0, 'h0,  'h0,  0, 0, 'h0,  'h0);
        vecs[20] = mk(0, 1, 'h200, 0, 0, 'h208, 0, 0, 1, 0, 0, 'h0,  'h0,  0, 0, 'h0,  'h0);
        vecs[21] = mk(0, 0, 'h0,   0, 0, 'h0,   0, 2, 1, 1, 1, 'h200, 'h204, 0, 0, 'h204, 'h208);

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(vecs[i].flush, vecs[i].ev, vecs[i].pc, vecs[i].inv2, vecs[i].pred,
                  vecs[i].npc, vecs[i].dr);
            #1;
            chk($sformatf("v%0d.count", i), 64'(count), 64'(vecs[i].cnt));
            chk($sformatf("v%0d.enq_ready", i), 64'(enq_ready), 64'(vecs[i].rdy));
            chk($sformatf("v%0d.valid1", i), 64'(deq_valid1), 64'(vecs[i].v1));
            chk($sformatf("v%0d.valid2", i), 64'(deq_valid2), 64'(vecs[i].v2));
            chk($sformatf("v%0d.pc1", i), 64'(deq_pc1), 64'(vecs[i].pc1));
            chk($sformatf("v%0d.pc2", i), 64'(deq_pc2), 64'(vecs[i].pc2));
            chk($sformatf("v%0d.pred1", i), 64'(deq_pred1), 64'(vecs[i].pred1));
            chk($sformatf("v%0d.pred2", i), 64'(deq_pred2), 64'(vecs[i].pred2));
            chk($sformatf("v%0d.npc1", i), 64'(deq_npc1), 64'(vecs[i].npc1));
            chk($sformatf("v%0d.npc2", i), 64'(deq_npc2), 64'(vecs[i].npc2));
            chk($sformatf("v%0d.inst1", i), 64'(deq_inst1),
                64'(vecs[i].v1 ? inst_of(vecs[i].pc1) : 32'h0));
            chk($sformatf("v%0d.inst2", i), 64'(deq_inst2),
                64'(vecs[i].v2 ? inst_of(vecs[i].pc2) : 32'h0));
        end

        // Reset while holding two entries and offering an enqueue.
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h308, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("midreset.count", 64'(count), 64'd0);
        chk("midreset.valid1", 64'(deq_valid1), 64'd0);
        chk("midreset.enq_ready", 64'(enq_ready), 64'd1);

        // Fill to seven entries; one free slot is not enough for a pair.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 32'h400 + 32'(k * 8), k == 3, 1'b0, 32'h408 + 32'(k * 8), 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 32'h508, 1'b0);
        #1;
        chk("full7.count", 64'(count), 64'd7);
        chk("full7.enq_ready", 64'(enq_ready), 64'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        chk("full7.ignored_enq", 64'(count), 64'd7);
        chk("full7.pc1", 64'(deq_pc1), 64'h400);
        chk("full7.pc2", 64'(deq_pc2), 64'h404);
        chk("full7.bhr1", 64'(deq_bhr1), 64'h100);
        chk("full7.bhr2", 64'(deq_bhr2), 64'h100);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("drain.count", 64'(count), 64'd5);
        chk("drain.pc1", 64'(deq_pc1), 64'h408);
        chk("drain.bhr1", 64'(deq_bhr1), 64'h102);
        chk("drain.enq_ready", 64'(enq_ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
